// File: rtl/calc_operand_stack_if.sv
// calc_operand_stack_if: keypad-event and ALU bus of the calculator operand stack
interface calc_operand_stack_if #(parameter int DIGITS = 4, parameter int DEPTH = 4);
   localparam int W  = 4 * DIGITS + 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic          clr_all, newhex, newop, eq, bs, ce, neg;
   logic [3:0]    hexcode;
   logic [W-1:0]  answer, entry, top;
   logic [CW-1:0] depth;
   logic          entry_full, push_drop;
   modport master (
      output clr_all, newhex, hexcode, newop, eq, bs, ce, neg, answer,
      input  entry, top, depth, entry_full, push_drop
   );
   modport slave (
      input  clr_all, newhex, hexcode, newop, eq, bs, ce, neg, answer,
      output entry, top, depth, entry_full, push_drop
   );
endinterface

// File: rtl/calc_operand_stack.sv
// calc_operand_stack: sign-magnitude entry register plus DEPTH-deep operand stack for the hex calculator
module calc_operand_stack #(
   parameter int DIGITS = 4,
   parameter int DEPTH  = 4
) (
   input logic                 clock,
   input logic                 reset,
   calc_operand_stack_if.slave bus
);
   localparam int W  = 4 * DIGITS + 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int NW = $clog2(DIGITS + 1);
   typedef enum logic {ENTRY, RESULT} state_t;
   state_t        state_q, state_d;
   logic [W-1:0]  entry_q, entry_d;
   logic [W-1:0]  stack_q [DEPTH];
   logic [W-1:0]  stack_d [DEPTH];
   logic [CW-1:0] depth_q, depth_d;
   logic [NW-1:0] ndig_q, ndig_d, ans_nd;
   logic          drop_q, drop_d;
   logic [W-2:0]  mag, bs_mag;
   assign mag    = entry_q[W-2:0];
   assign bs_mag = mag >> 4;
   always_ff @(posedge clock) begin
      if (reset || bus.clr_all) state_q <= ENTRY;
      else                      state_q <= state_d;
   end
   always_ff @(posedge clock) begin
      if (reset || bus.clr_all) begin
         entry_q <= '0;
         depth_q <= '0;
         ndig_q  <= '0;
         drop_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      end else begin
         entry_q <= entry_d;
         depth_q <= depth_d;
         ndig_q  <= ndig_d;
         drop_q  <= drop_d;
         for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
      end
   end
   always_comb state_d = bus.ce ? ENTRY : (bus.eq || bus.newop) ? RESULT : (bus.bs || bus.newhex) ? ENTRY : state_q;
   // significant-digit count of the incoming answer: highest nonzero nibble + 1
   always_comb begin
      ans_nd = '0;
      for (int i = 0; i < DIGITS; i++) if (bus.answer[4*i +: 4] != 4'd0) ans_nd = NW'(i + 1);
   end
   always_comb begin
      entry_d = entry_q;
      depth_d = depth_q;
      ndig_d  = ndig_q;
      drop_d  = 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_d[i] = stack_q[i];
      if (bus.ce) begin
         entry_d = '0;
         ndig_d  = '0;
      end else if (bus.eq) begin
         entry_d = {bus.answer[W-1] & (|bus.answer[W-2:0]), bus.answer[W-2:0]};
         ndig_d  = ans_nd;
         if (depth_q != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
            stack_d[DEPTH-1] = '0;
            depth_d          = depth_q - 1'b1;
         end
      end else if (bus.newop) begin
         for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
         stack_d[0] = entry_q;
         if (depth_q == CW'(DEPTH)) drop_d = 1'b1;
         else                       depth_d = depth_q + 1'b1;
      end else if (bus.bs) begin
         entry_d = state_q == RESULT ? '0 : {entry_q[W-1] & (|bs_mag), bs_mag};
         ndig_d  = (state_q == RESULT || ndig_q == '0) ? '0 : ndig_q - 1'b1;
      end else if (bus.newhex) begin
         if (state_q == RESULT) begin
            entry_d = {1'b0, {(W-5){1'b0}}, bus.hexcode};
            ndig_d  = NW'(bus.hexcode != 4'd0);
         end else if (ndig_q != NW'(DIGITS)) begin
            entry_d = {entry_q[W-1], mag[W-6:0], bus.hexcode};
            if (mag != '0 || bus.hexcode != 4'd0) ndig_d = ndig_q + 1'b1;
         end
      end else if (bus.neg) begin
         entry_d[W-1] = entry_q[W-1] ^ (|mag);
      end
   end
   assign bus.entry      = entry_q;
   assign bus.top        = stack_q[0];
   assign bus.depth      = depth_q;
   assign bus.entry_full = ndig_q == NW'(DIGITS);
   assign bus.push_drop  = drop_q;
endmodule

// File: tb/tb_calc_operand_stack.sv
// tb_calc_operand_stack: vector table, corner sequences and randomized model check of calc_operand_stack
module tb_calc_operand_stack;
   localparam int DIGITS = 4;
   localparam int DEPTH  = 4;
   localparam int W      = 4 * DIGITS + 1;
   localparam logic [6:0] CLR = 7'b1000000, CE = 7'b0100000, EQ = 7'b0010000, OP = 7'b0001000;
   localparam logic [6:0] BS = 7'b0000100, HX = 7'b0000010, NG = 7'b0000001, NONE = 7'b0;
   typedef struct {
      logic [6:0]   ev;
      logic [3:0]   h;
      logic [W-1:0] ans, e_entry, e_top;
      int           e_depth;
      bit           e_full, e_drop;
   } vec_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   calc_operand_stack_if #(.DIGITS(DIGITS), .DEPTH(DEPTH)) bus ();
   calc_operand_stack #(.DIGITS(DIGITS), .DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));
   int n_chk = 0;
   int n_pass = 0;
   vec_t tbl[$];
   bit           m_sign, m_res, m_drop;
   int           m_mag;
   logic [W-1:0] m_stk[$];
   function automatic vec_t v(logic [6:0] ev, logic [3:0] h, logic [W-1:0] ans, logic [W-1:0] en,
                              logic [W-1:0] tp, int d, bit f, bit dr);
      v.ev = ev; v.h = h; v.ans = ans; v.e_entry = en; v.e_top = tp; v.e_depth = d; v.e_full = f; v.e_drop = dr;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic check_out(input string tag, input logic [W-1:0] en, input logic [W-1:0] tp, input int d,
                            input bit f, input bit dr);
      chk({tag, ".entry"}, 32'(bus.entry), 32'(en));
      chk({tag, ".top"}, 32'(bus.top), 32'(tp));
      chk({tag, ".depth"}, 32'(bus.depth), 32'(d));
      chk({tag, ".full"}, 32'(bus.entry_full), 32'(f));
      chk({tag, ".drop"}, 32'(bus.push_drop), 32'(dr));
   endtask
   task automatic drive(input logic [6:0] ev, input logic [3:0] h, input logic [W-1:0] ans);
      {bus.clr_all, bus.ce, bus.eq, bus.newop, bus.bs, bus.newhex, bus.neg} = ev;
      bus.hexcode = h;
      bus.answer  = ans;
      @(posedge clock);
      #1;
      {bus.clr_all, bus.ce, bus.eq, bus.newop, bus.bs, bus.newhex, bus.neg} = NONE;
   endtask
   // reference: entry as sign + integer magnitude, stack as a queue with the top at the front
   task automatic model(input logic [6:0] ev, input logic [3:0] h, input logic [W-1:0] ans);
      m_drop = 0;
      if (ev[6]) begin
         m_mag = 0; m_sign = 0; m_res = 0; m_stk.delete();
      end else if (ev[5]) begin
         m_mag = 0; m_sign = 0; m_res = 0;
      end else if (ev[4]) begin
         m_mag = int'(ans[W-2:0]); m_sign = ans[W-1] && m_mag != 0; m_res = 1;
         if (m_stk.size() > 0) void'(m_stk.pop_front());
      end else if (ev[3]) begin
         m_stk.push_front({m_sign, 16'(m_mag)});
         if (m_stk.size() > DEPTH) begin void'(m_stk.pop_back()); m_drop = 1; end
         m_res = 1;
      end else if (ev[2]) begin
         m_mag = m_res ? 0 : m_mag / 16;
         if (m_mag == 0) m_sign = 0;
         m_res = 0;
      end else if (ev[1]) begin
         if (m_res) begin m_mag = int'(h); m_sign = 0; end
         else if (m_mag < 16 ** (DIGITS - 1)) m_mag = m_mag * 16 + int'(h);
         m_res = 0;
      end else if (ev[0]) begin
         if (m_mag != 0) m_sign = !m_sign;
      end
   endtask
   initial begin
      logic [6:0]   ev;
      logic [3:0]   h;
      logic [W-1:0] ans;
      int           r;
      {bus.clr_all, bus.ce, bus.eq, bus.newop, bus.bs, bus.newhex, bus.neg} = NONE;
      bus.hexcode = 4'h0;
      bus.answer  = '0;
      bus.newhex  = 1'b1;
      bus.hexcode = 4'h7;
      repeat (3) @(posedge clock);
      #1;
      bus.newhex = 1'b0;
      check_out("reset", '0, '0, 0, 0, 0);
      reset = 1'b0;
      tbl.push_back(v(HX, 4'h1, '0, 17'h00001, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h2, '0, 17'h00012, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h3, '0, 17'h00123, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h4, '0, 17'h01234, '0, 0, 1, 0));
      tbl.push_back(v(HX, 4'h5, '0, 17'h01234, '0, 0, 1, 0));
      tbl.push_back(v(CE, 4'h0, '0, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h0, '0, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h0, '0, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h7, '0, 17'h00007, '0, 0, 0, 0));
      tbl.push_back(v(BS, 4'h0, '0, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(BS, 4'h0, '0, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h1, '0, 17'h00001, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h2, '0, 17'h00012, '0, 0, 0, 0));
      tbl.push_back(v(NG, 4'h0, '0, 17'h10012, '0, 0, 0, 0));
      tbl.push_back(v(BS, 4'h0, '0, 17'h10001, '0, 0, 0, 0));
      tbl.push_back(v(BS, 4'h0, '0, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(NG, 4'h0, '0, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h5, '0, 17'h00005, '0, 0, 0, 0));
      tbl.push_back(v(OP, 4'h0, '0, 17'h00005, 17'h00005, 1, 0, 0));
      tbl.push_back(v(HX, 4'h9, '0, 17'h00009, 17'h00005, 1, 0, 0));
      tbl.push_back(v(EQ, 4'h0, 17'h0000E, 17'h0000E, '0, 0, 0, 0));
      tbl.push_back(v(OP | HX, 4'h3, '0, 17'h0000E, 17'h0000E, 1, 0, 0));
      tbl.push_back(v(HX, 4'h3, '0, 17'h00003, 17'h0000E, 1, 0, 0));
      tbl.push_back(v(CLR | EQ, 4'h0, 17'h1FFFF, '0, '0, 0, 0, 0));
      tbl.push_back(v(EQ, 4'h0, 17'h10000, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(EQ, 4'h0, 17'h10AB0, 17'h10AB0, '0, 0, 0, 0));
      tbl.push_back(v(HX, 4'h1, '0, 17'h00001, '0, 0, 0, 0));
      tbl.push_back(v(EQ, 4'h0, 17'h0F000, 17'h0F000, '0, 0, 1, 0));
      tbl.push_back(v(BS, 4'h0, '0, 17'h00000, '0, 0, 0, 0));
      tbl.push_back(v(CE | EQ, 4'h0, 17'h00042, 17'h00000, '0, 0, 0, 0));
      foreach (tbl[i]) begin
         drive(tbl[i].ev, tbl[i].h, tbl[i].ans);
         check_out($sformatf("vec%0d", i), tbl[i].e_entry, tbl[i].e_top, tbl[i].e_depth, tbl[i].e_full, tbl[i].e_drop);
      end
      drive(CLR, 4'h0, '0);
      for (int k = 1; k <= 5; k++) begin
         drive(HX, 4'(k), '0);
         drive(OP, 4'h0, '0);
         check_out($sformatf("push%0d", k), W'(k), W'(k), k > DEPTH ? DEPTH : k, 0, k > DEPTH);
      end
      drive(NONE, 4'h0, '0);
      chk("drop_one_cycle", 32'(bus.push_drop), 32'(0));
      for (int k = 4; k >= 2; k--) begin
         drive(EQ, 4'h0, '0);
         check_out($sformatf("pop_top%0d", k), '0, W'(k), k - 1, 0, 0);
      end
      drive(EQ, 4'h0, '0);
      check_out("pop_last", '0, '0, 0, 0, 0);
      drive(EQ, 4'h0, 17'h00123);
      check_out("pop_empty", 17'h00123, '0, 0, 0, 0);
      drive(CLR, 4'h0, '0);
      model(CLR, 4'h0, '0);
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 19);
         if (r < 6) ev = 7'(1 << r);
         else if (r < 13) ev = HX;
         else if (r < 15) ev = OP;
         else if (r == 15) ev = 7'(1 << $urandom_range(0, 5)) | 7'(1 << $urandom_range(0, 5));
         else if (r == 16) ev = ($urandom_range(0, 3) == 0) ? CLR : NG;
         else ev = NONE;
         h   = 4'($urandom_range(0, 15));
         ans = W'($urandom);
         if ($urandom_range(0, 3) == 0) ans[W-2:0] = W'($urandom_range(0, 255)) & {1'b0, {(W-1){1'b1}}};
         drive(ev, h, ans);
         model(ev, h, ans);
         check_out("rnd", {m_sign, 16'(m_mag)}, m_stk.size() > 0 ? m_stk[0] : '0, m_stk.size(),
                   m_mag >= 16 ** (DIGITS - 1), m_drop);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
